// File: rtl/dram_read_engine.sv
`default_nettype none
// ============================================================================
// dram_read_engine: splits a word-count read request into 4 KB-safe AXI4 INCR
// bursts and streams the returned words, in address order, to the consumer.
// Revision: 1.0
// ============================================================================
module dram_read_engine #(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       read_num,
  input  logic [31:0]       read_addr,
  output logic [31:0]       buf_dout,
  output logic              buf_we,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_AR   = 3'd2,
    S_R    = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [8:0] C_MAX_BURST = 9'(MAX_BURST);

  state_t            state_q, state_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [31:0]       buf_dout_q, buf_dout_d;
  logic              buf_we_q, buf_we_d;
  logic              err_q, err_d;

  logic [12:0]       page_bytes;
  logic [10:0]       page_words;
  logic [8:0]        rem_cap;
  logic [8:0]        burst_len;
  logic              last_beat;

  // Burst length: bounded by what is left, MAX_BURST and the words to the next 4 KB page.
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    page_words = page_bytes[12:2];
    rem_cap    = (remaining_q > {23'd0, C_MAX_BURST}) ? C_MAX_BURST : remaining_q[8:0];
    burst_len  = ({2'b00, rem_cap} > page_words) ? page_words[8:0] : rem_cap;
    last_beat  = (beat_q == (len_q - 9'd1));
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_d      = beat_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    buf_dout_d  = buf_dout_q;
    buf_we_d    = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (kick) begin
          cur_addr_d  = read_addr & 32'hFFFF_FFFC;
          remaining_d = read_num;
          err_d       = 1'b0;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (remaining_q == 32'd0) begin
          state_d = S_DONE;
        end else begin
          len_d    = burst_len;
          araddr_d = ADDR_W'(cur_addr_q);
          // A 256-beat burst has low byte 0, so the 8-bit subtract still yields 255.
          arlen_d  = burst_len[7:0] - 8'd1;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          cur_addr_d  = cur_addr_q + {21'd0, len_q, 2'b00};
          remaining_d = remaining_q - {23'd0, len_q};
          beat_d      = 9'd0;
          state_d     = S_R;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          buf_dout_d = m_axi_rdata;
          buf_we_d   = 1'b1;
          beat_d     = beat_q + 9'd1;
          if (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = (remaining_q == 32'd0) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= 32'd0;
      remaining_q <= 32'd0;
      len_q       <= 9'd0;
      beat_q      <= 9'd0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      buf_dout_q  <= 32'd0;
      buf_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      buf_dout_q  <= buf_dout_d;
      buf_we_q    <= buf_we_d;
      err_q       <= err_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = (state_q == S_R);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign buf_dout      = buf_dout_q;
  assign buf_we        = buf_we_q;
  assign err           = err_q;

endmodule
`default_nettype wire
